// File: rtl/a2d_rr_intf.sv
// SPI master for the ADC128S: each nxt runs two 16-bit frames on the current channel, round-robin 0/4/5/6.
// Optional macro A2D_FILTER_EN averages each new result with the previous one held for that channel.
module a2d_rr_intf #(
    parameter int SCLK_DIV_W = 5
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        nxt,
    input  logic        MISO,
    output logic        SS_n,
    output logic        SCLK,
    output logic        MOSI,
    output logic [11:0] lft_ld,
    output logic [11:0] rght_ld,
    output logic [11:0] steer_pot,
    output logic [11:0] batt,
    output logic        cnv_cmplt
);

    localparam logic [SCLK_DIV_W-1:0] DIV_ONE  = 1;
    localparam logic [SCLK_DIV_W-1:0] DIV_FALL = '1;
    localparam logic [SCLK_DIV_W-1:0] DIV_SMP  = DIV_FALL >> 1;
    localparam logic [SCLK_DIV_W-1:0] DIV_PRE  = DIV_FALL ^ (DIV_ONE << (SCLK_DIV_W - 2));

    typedef enum logic [2:0] {IDLE, TX1, GAP, TX2, DONE} state_t;

    state_t                  state_q, state_d;
    logic [15:0]             shft_q, shft_d;
    logic [SCLK_DIV_W-1:0]   div_q, div_d;
    logic                    ss_n_q, ss_n_d;
    logic [4:0]              bit_cnt_q, bit_cnt_d;
    logic                    first_q, first_d;
    logic                    gap_q, gap_d;
    logic [1:0]              ptr_q, ptr_d;
    logic                    cnv_q, cnv_d;
    logic [3:0][11:0]        res_q;
    logic                    wr_en;
    logic [11:0]             wr_val;
    logic [15:0]             cmd;

    function automatic logic [2:0] chnl_of(input logic [1:0] idx);
        case (idx)
            2'd0:    return 3'd0;
            2'd1:    return 3'd4;
            2'd2:    return 3'd5;
            default: return 3'd6;
        endcase
    endfunction

    assign cmd = {2'b00, chnl_of(ptr_q), 11'h000};

    always_comb begin
        state_d   = state_q;
        shft_d    = shft_q;
        div_d     = div_q;
        ss_n_d    = ss_n_q;
        bit_cnt_d = bit_cnt_q;
        first_d   = first_q;
        gap_d     = gap_q;
        ptr_d     = ptr_q;
        cnv_d     = 1'b0;
        wr_en     = 1'b0;
        case (state_q)
            IDLE: begin
                if (nxt) begin
                    shft_d    = cmd;
                    ss_n_d    = 1'b0;
                    div_d     = DIV_PRE;
                    bit_cnt_d = 5'd0;
                    first_d   = 1'b1;
                    state_d   = TX1;
                end
            end
            TX1, TX2: begin
                div_d = div_q + DIV_ONE;
                if (div_q == DIV_SMP) begin
                    shft_d[0] = MISO;
                    bit_cnt_d = bit_cnt_q + 5'd1;
                end else if (div_q == DIV_FALL) begin
                    // The fall preceding the first rise must not shift: cmd[15] is already on MOSI.
                    if (first_q) begin
                        first_d = 1'b0;
                    end else if (bit_cnt_q == 5'd16) begin
                        ss_n_d  = 1'b1;
                        gap_d   = 1'b0;
                        state_d = (state_q == TX1) ? GAP : DONE;
                    end else begin
                        shft_d = {shft_q[14:0], 1'b0};
                    end
                end
            end
            GAP: begin
                shft_d = cmd;
                if (gap_q) begin
                    ss_n_d    = 1'b0;
                    div_d     = DIV_PRE;
                    bit_cnt_d = 5'd0;
                    first_d   = 1'b1;
                    state_d   = TX2;
                end else begin
                    gap_d = 1'b1;
                end
            end
            DONE: begin
                wr_en   = 1'b1;
                cnv_d   = 1'b1;
                ptr_d   = ptr_q + 2'd1;
                state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= IDLE;
            shft_q    <= 16'h0000;
            div_q     <= DIV_PRE;
            ss_n_q    <= 1'b1;
            bit_cnt_q <= 5'd0;
            first_q   <= 1'b0;
            gap_q     <= 1'b0;
            ptr_q     <= 2'd0;
            cnv_q     <= 1'b0;
        end else begin
            state_q   <= state_d;
            shft_q    <= shft_d;
            div_q     <= div_d;
            ss_n_q    <= ss_n_d;
            bit_cnt_q <= bit_cnt_d;
            first_q   <= first_d;
            gap_q     <= gap_d;
            ptr_q     <= ptr_d;
            cnv_q     <= cnv_d;
        end
    end

`ifdef A2D_FILTER_EN
    logic [3:0]  seen_q;
    logic [12:0] sum;

    assign sum    = {1'b0, res_q[ptr_q]} + {1'b0, shft_q[11:0]};
    assign wr_val = seen_q[ptr_q] ? sum[12:1] : shft_q[11:0];

    // First write after reset has no history to average with, so it loads raw.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            seen_q <= 4'b0000;
        end else if (wr_en) begin
            seen_q[ptr_q] <= 1'b1;
        end
    end
`else
    assign wr_val = shft_q[11:0];
`endif

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            res_q <= '0;
        end else if (wr_en) begin
            res_q[ptr_q] <= wr_val;
        end
    end

    assign SS_n      = ss_n_q;
    assign SCLK      = ss_n_q | div_q[SCLK_DIV_W-1];
    assign MOSI      = ~ss_n_q & shft_q[15];
    assign cnv_cmplt = cnv_q;
    assign lft_ld    = res_q[0];
    assign rght_ld   = res_q[1];
    assign steer_pot = res_q[2];
    assign batt      = res_q[3];

endmodule
